// File: rtl/noc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : noc_pkg
//  Description : Shared NoC definitions for the spine switch and group routers.
//                Holds the flit width, the destination/group address field
//                positions, the number of groups and the flit type.
//  Revision    : 1.0 - initial release
// ============================================================================
package noc_pkg;

    localparam int DWIDTH     = 16;
    localparam int NUM_GROUPS = 4;

    // dest_addr lives in flit[15:10]; the group index is dest_addr[3:2].
    localparam int DEST_MSB   = 15;
    localparam int DEST_LSB   = 10;
    localparam int GROUP_MSB  = 3;
    localparam int GROUP_LSB  = 2;

    localparam int DEST_W     = DEST_MSB - DEST_LSB + 1;
    localparam int GIDX_W     = GROUP_MSB - GROUP_LSB + 1;

    typedef logic [DWIDTH-1:0] flit_t;

    // Destination group index of a flit. dest_addr[5:4] plays no part.
    function automatic logic [GIDX_W-1:0] group_of(input flit_t f);
        return f[DEST_LSB+GROUP_MSB : DEST_LSB+GROUP_LSB];
    endfunction

endpackage : noc_pkg
`default_nettype wire

// File: rtl/spine_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : spine_fifo
//  Description : Synchronous FIFO for one spine input.
//                The pointers wrap modulo FIFO_DEPTH, which must be a power of
//                two and at least 2. A push into a full FIFO is accepted when a
//                pop happens in the same cycle.
//  Ports       : clk, reset  - clock, synchronous active-high reset
//                push_i      - write request (data_i)
//                pop_i       - read request, removes head_o
//                head_o      - oldest entry (valid when !empty_o)
//                full_o      - FIFO holds FIFO_DEPTH entries
//                empty_o     - FIFO holds no entries
//  Revision    : 1.0 - initial release
// ============================================================================
module spine_fifo #(
    parameter int DWIDTH     = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [DWIDTH-1:0] data_i,
    output logic [DWIDTH-1:0] head_o,
    output logic              full_o,
    output logic              empty_o
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [DWIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       count_q,  count_d;
    logic              do_push,  do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (AW+1)'(FIFO_DEPTH));
    assign head_o  = mem_q[rd_ptr_q];

    assign do_pop  = pop_i && !empty_o;
    // A full FIFO frees its head slot in the same cycle it is popped.
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule : spine_fifo
`default_nettype wire

// File: rtl/spine_switch.sv
`default_nettype none
// ============================================================================
//  Module      : spine_switch
//  Description : One spine of the group-router network. Flits from the four
//                group routers are buffered per input, then switched to the
//                group named by dest_addr[3:2] through one round-robin arbiter
//                per output. There is no backpressure: a flit that meets a
//                full FIFO is dropped and counted.
//  Ports       : clk, reset              - clock, synchronous active-high reset
//                gK_in_data/valid        - flit from group K router (K=1..4)
//                gK_out_data/valid       - registered flit to group K router
//                gK_out_dest_addr        - gK_out_data[15:10]
//                gK_drop_cnt             - saturating drop count of input K
//  Revision    : 1.0 - initial release
// ============================================================================
module spine_switch
    import noc_pkg::*;
#(
    parameter int SPINE_ID   = 1,
    parameter int DWIDTH     = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,

    input  logic [DWIDTH-1:0] g1_in_data,
    input  logic              g1_in_valid,
    input  logic [DWIDTH-1:0] g2_in_data,
    input  logic              g2_in_valid,
    input  logic [DWIDTH-1:0] g3_in_data,
    input  logic              g3_in_valid,
    input  logic [DWIDTH-1:0] g4_in_data,
    input  logic              g4_in_valid,

    output logic [DWIDTH-1:0] g1_out_data,
    output logic              g1_out_valid,
    output logic [5:0]        g1_out_dest_addr,
    output logic [7:0]        g1_drop_cnt,
    output logic [DWIDTH-1:0] g2_out_data,
    output logic              g2_out_valid,
    output logic [5:0]        g2_out_dest_addr,
    output logic [7:0]        g2_drop_cnt,
    output logic [DWIDTH-1:0] g3_out_data,
    output logic              g3_out_valid,
    output logic [5:0]        g3_out_dest_addr,
    output logic [7:0]        g3_drop_cnt,
    output logic [DWIDTH-1:0] g4_out_data,
    output logic              g4_out_valid,
    output logic [5:0]        g4_out_dest_addr,
    output logic [7:0]        g4_drop_cnt
);

    // SPINE_ID is informational. An out-of-range value is a system build
    // error; such an instance stays silent rather than forwarding traffic.
    localparam logic SPINE_ID_OK = (SPINE_ID >= 1) && (SPINE_ID <= 4);

    localparam logic [7:0] DROP_MAX = 8'hFF;

    // ------------------------------------------------------------------------
    // Port bundling: index 0..3 corresponds to group 1..4
    // ------------------------------------------------------------------------
    logic [DWIDTH-1:0]     in_data  [NUM_GROUPS];
    logic [NUM_GROUPS-1:0] in_valid;
    logic [DWIDTH-1:0]     head     [NUM_GROUPS];
    logic [NUM_GROUPS-1:0] empty;
    logic [NUM_GROUPS-1:0] full;
    logic [NUM_GROUPS-1:0] pop;
    logic [NUM_GROUPS-1:0] req      [NUM_GROUPS];   // req[output][input]
    logic [NUM_GROUPS-1:0] gnt      [NUM_GROUPS];   // gnt[output][input]
    logic [DWIDTH-1:0]     out_data [NUM_GROUPS];
    logic [NUM_GROUPS-1:0] out_valid;
    logic [7:0]            drop_cnt [NUM_GROUPS];

    assign in_data[0] = g1_in_data;
    assign in_data[1] = g2_in_data;
    assign in_data[2] = g3_in_data;
    assign in_data[3] = g4_in_data;
    assign in_valid   = {g4_in_valid, g3_in_valid, g2_in_valid, g1_in_valid};

    // ------------------------------------------------------------------------
    // Input stage: one FIFO and one drop counter per input
    // ------------------------------------------------------------------------
    for (genvar i = 0; i < NUM_GROUPS; i++) begin : g_in
        logic [7:0] drop_cnt_q, drop_cnt_d;
        logic       drop;

        spine_fifo #(
            .DWIDTH     (DWIDTH),
            .FIFO_DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk     (clk),
            .reset   (reset),
            .push_i  (in_valid[i]),
            .pop_i   (pop[i]),
            .data_i  (in_data[i]),
            .head_o  (head[i]),
            .full_o  (full[i]),
            .empty_o (empty[i])
        );

        // Mirrors the FIFO accept rule: full and not popped means lost.
        assign drop = in_valid[i] && full[i] && !pop[i];

        always_comb begin
            drop_cnt_d = drop_cnt_q;
            if (drop && (drop_cnt_q != DROP_MAX)) begin
                drop_cnt_d = drop_cnt_q + 8'd1;
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                drop_cnt_q <= '0;
            end else begin
                drop_cnt_q <= drop_cnt_d;
            end
        end

        assign drop_cnt[i] = drop_cnt_q;
    end

    // ------------------------------------------------------------------------
    // Request matrix: each non-empty head requests exactly one output, so an
    // input can never collect more than one grant per cycle.
    // ------------------------------------------------------------------------
    always_comb begin
        for (int j = 0; j < NUM_GROUPS; j++) begin
            req[j] = '0;
        end
        for (int i = 0; i < NUM_GROUPS; i++) begin
            if (!empty[i] && SPINE_ID_OK) begin
                req[group_of(head[i][DEST_MSB:0])][i] = 1'b1;
            end
        end
    end

    always_comb begin
        pop = '0;
        for (int j = 0; j < NUM_GROUPS; j++) begin
            pop = pop | gnt[j];
        end
    end

    // ------------------------------------------------------------------------
    // Switch stage: one round-robin arbiter and output register per output
    // ------------------------------------------------------------------------
    for (genvar j = 0; j < NUM_GROUPS; j++) begin : g_arb
        logic [GIDX_W-1:0]     last_q, last_d;     // last granted input
        logic [GIDX_W-1:0]     gnt_idx, scan_idx;
        logic                  gnt_any;
        logic [NUM_GROUPS-1:0] gnt_vec;
        logic                  out_valid_q;
        logic [DWIDTH-1:0]     out_data_q, out_data_d;

        // Scan from the input after the last winner; k = NUM_GROUPS wraps back
        // to the last winner itself, which therefore has lowest priority.
        always_comb begin
            gnt_any  = 1'b0;
            gnt_idx  = last_q;
            scan_idx = last_q;
            for (int k = 1; k <= NUM_GROUPS; k++) begin
                scan_idx = last_q + GIDX_W'(k);
                if (!gnt_any && req[j][scan_idx]) begin
                    gnt_any = 1'b1;
                    gnt_idx = scan_idx;
                end
            end
            gnt_vec          = '0;
            gnt_vec[gnt_idx] = gnt_any;
            last_d           = gnt_any ? gnt_idx : last_q;
            out_data_d       = gnt_any ? head[gnt_idx] : '0;
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                // Pointing at the last input makes input 1 the first choice.
                last_q      <= GIDX_W'(NUM_GROUPS - 1);
                out_valid_q <= 1'b0;
                out_data_q  <= '0;
            end else begin
                last_q      <= last_d;
                out_valid_q <= gnt_any;
                out_data_q  <= out_data_d;
            end
        end

        assign gnt[j]       = gnt_vec;
        assign out_valid[j] = out_valid_q;
        assign out_data[j]  = out_data_q;
    end

    // ------------------------------------------------------------------------
    // Output unbundling
    // ------------------------------------------------------------------------
    assign g1_out_data      = out_data[0];
    assign g1_out_valid     = out_valid[0];
    assign g1_out_dest_addr = out_data[0][DEST_MSB:DEST_LSB];
    assign g1_drop_cnt      = drop_cnt[0];

    assign g2_out_data      = out_data[1];
    assign g2_out_valid     = out_valid[1];
    assign g2_out_dest_addr = out_data[1][DEST_MSB:DEST_LSB];
    assign g2_drop_cnt      = drop_cnt[1];

    assign g3_out_data      = out_data[2];
    assign g3_out_valid     = out_valid[2];
    assign g3_out_dest_addr = out_data[2][DEST_MSB:DEST_LSB];
    assign g3_drop_cnt      = drop_cnt[2];

    assign g4_out_data      = out_data[3];
    assign g4_out_valid     = out_valid[3];
    assign g4_out_dest_addr = out_data[3][DEST_MSB:DEST_LSB];
    assign g4_drop_cnt      = drop_cnt[3];

endmodule : spine_switch
`default_nettype wire

// File: tb/tb_spine_switch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spine_switch
//  Description : Directed self-checking bench for spine_switch (defaults:
//                DWIDTH=16, FIFO_DEPTH=4). Inputs are driven 1 time unit after
//                the rising edge and outputs are sampled at the same point.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spine_switch;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] g1_in_data, g2_in_data, g3_in_data, g4_in_data;
    logic        g1_in_valid, g2_in_valid, g3_in_valid, g4_in_valid;
    logic [15:0] g1_out_data, g2_out_data, g3_out_data, g4_out_data;
    logic        g1_out_valid, g2_out_valid, g3_out_valid, g4_out_valid;
    logic [5:0]  g1_out_dest_addr, g2_out_dest_addr, g3_out_dest_addr, g4_out_dest_addr;
    logic [7:0]  g1_drop_cnt, g2_drop_cnt, g3_drop_cnt, g4_drop_cnt;

    int checks = 0;
    int fails  = 0;

    logic [3:0]  vld;
    logic [63:0] dat;
    logic [23:0] dst;
    logic [31:0] drops;

    assign vld   = {g4_out_valid, g3_out_valid, g2_out_valid, g1_out_valid};
    assign dat   = {g4_out_data, g3_out_data, g2_out_data, g1_out_data};
    assign dst   = {g4_out_dest_addr, g3_out_dest_addr, g2_out_dest_addr, g1_out_dest_addr};
    assign drops = {g4_drop_cnt, g3_drop_cnt, g2_drop_cnt, g1_drop_cnt};

    // Flits from input g2 seen on output g1 (source tag in bits [7:4]).
    logic [7:0] mon_q[$];
    logic       mon_en = 1'b0;

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mon_en && g1_out_valid && (g1_out_data[7:4] == 4'd2)) begin
            mon_q.push_back(g1_out_data[7:0]);
        end
    end

    spine_switch #(
        .SPINE_ID   (1),
        .DWIDTH     (16),
        .FIFO_DEPTH (4)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .g1_in_data       (g1_in_data),
        .g1_in_valid      (g1_in_valid),
        .g2_in_data       (g2_in_data),
        .g2_in_valid      (g2_in_valid),
        .g3_in_data       (g3_in_data),
        .g3_in_valid      (g3_in_valid),
        .g4_in_data       (g4_in_data),
        .g4_in_valid      (g4_in_valid),
        .g1_out_data      (g1_out_data),
        .g1_out_valid     (g1_out_valid),
        .g1_out_dest_addr (g1_out_dest_addr),
        .g1_drop_cnt      (g1_drop_cnt),
        .g2_out_data      (g2_out_data),
        .g2_out_valid     (g2_out_valid),
        .g2_out_dest_addr (g2_out_dest_addr),
        .g2_drop_cnt      (g2_drop_cnt),
        .g3_out_data      (g3_out_data),
        .g3_out_valid     (g3_out_valid),
        .g3_out_dest_addr (g3_out_dest_addr),
        .g3_drop_cnt      (g3_drop_cnt),
        .g4_out_data      (g4_out_data),
        .g4_out_valid     (g4_out_valid),
        .g4_out_dest_addr (g4_out_dest_addr),
        .g4_drop_cnt      (g4_drop_cnt)
    );

    // ---------------------------------------------------------------- helpers
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        g1_in_valid = 1'b0; g2_in_valid = 1'b0; g3_in_valid = 1'b0; g4_in_valid = 1'b0;
        g1_in_data  = '0;   g2_in_data  = '0;   g3_in_data  = '0;   g4_in_data  = '0;
    endtask

    task automatic drive(input int k, input logic [15:0] d);
        case (k)
            1: begin g1_in_data = d; g1_in_valid = 1'b1; end
            2: begin g2_in_data = d; g2_in_valid = 1'b1; end
            3: begin g3_in_data = d; g3_in_valid = 1'b1; end
            default: begin g4_in_data = d; g4_in_valid = 1'b1; end
        endcase
    endtask

    task automatic apply_reset();
        clear_inputs();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    // ------------------------------------------------------------------ tests
    task automatic test_reset();
        clear_inputs();
        reset = 1'b1;
        step();
        step();
        checks++; if (vld !== 4'h0) begin fails++; $display("FAIL reset_valid: got %b want 0000", vld); end
        checks++; if (dat !== 64'h0) begin fails++; $display("FAIL reset_data: got %h want 0", dat); end
        checks++; if (dst !== 24'h0) begin fails++; $display("FAIL reset_dest: got %h want 0", dst); end
        checks++; if (drops !== 32'h0) begin fails++; $display("FAIL reset_drops: got %h want 0", drops); end
        reset = 1'b0;
    endtask

    task automatic test_single_flit();
        apply_reset();
        drive(1, 16'h2C01);
        step();                         // sampled at edge N
        clear_inputs();
        checks++; if (vld !== 4'h0) begin fails++; $display("FAIL single_early: got %b want 0000", vld); end
        step();                         // edge N+1
        checks++; if (vld !== 4'b0100) begin fails++; $display("FAIL single_valid: got %b want 0100", vld); end
        checks++; if (g3_out_data !== 16'h2C01) begin fails++; $display("FAIL single_data: got %h want 2c01", g3_out_data); end
        checks++; if (g3_out_dest_addr !== 6'h0B) begin fails++; $display("FAIL single_dest: got %h want 0b", g3_out_dest_addr); end
        step();
        checks++; if (vld !== 4'h0) begin fails++; $display("FAIL single_pulse: got %b want 0000", vld); end
    endtask

    task automatic test_contention();
        logic [15:0] exp_d [3];
        exp_d[0] = 16'h0011; exp_d[1] = 16'h0021; exp_d[2] = 16'h0041;
        apply_reset();
        for (int r = 0; r < 2; r++) begin
            drive(1, 16'h0011);
            drive(2, 16'h0021);
            drive(4, 16'h0041);
            step();
            clear_inputs();
            for (int n = 0; n < 3; n++) begin
                step();
                checks++;
                if (vld !== 4'b0001 || g1_out_data !== exp_d[n]) begin
                    fails++;
                    $display("FAIL contention_r%0d_n%0d: got valid %b data %h want 0001 %h", r, n, vld, g1_out_data, exp_d[n]);
                end
            end
            step();
            checks++; if (vld !== 4'h0) begin fails++; $display("FAIL contention_idle_r%0d: got %b want 0000", r, vld); end
        end
    endtask

    task automatic test_parallel();
        apply_reset();
        drive(1, 16'h1011);
        drive(2, 16'h2022);
        drive(3, 16'h3033);
        drive(4, 16'h0044);
        step();
        clear_inputs();
        step();
        checks++; if (vld !== 4'hF) begin fails++; $display("FAIL parallel_valid: got %b want 1111", vld); end
        checks++; if (dat !== 64'h3033_2022_1011_0044) begin fails++; $display("FAIL parallel_data: got %h want 3033202210110044", dat); end
        checks++; if (dst !== {6'h0C, 6'h08, 6'h04, 6'h00}) begin fails++; $display("FAIL parallel_dest: got %h want %h", dst, {6'h0C, 6'h08, 6'h04, 6'h00}); end
        step();
        checks++; if (vld !== 4'h0) begin fails++; $display("FAIL parallel_pulse: got %b want 0000", vld); end
    endtask

    task automatic test_hairpin();
        apply_reset();
        drive(3, 16'h2055);
        step();
        clear_inputs();
        step();
        checks++;
        if (vld !== 4'b0100 || g3_out_data !== 16'h2055) begin
            fails++;
            $display("FAIL hairpin: got valid %b data %h want 0100 2055", vld, g3_out_data);
        end
    endtask

    // All four inputs stream to output g1 for 8 cycles: strict rotation pops
    // input K at edges K, K+4, so g1 is full-and-popped at edge 5 (accepted)
    // and drops from edge 6; g2 keeps flits 0-4 and 6.
    task automatic test_overflow_full_pop();
        logic [7:0] exp_m [6];
        exp_m[0] = 8'h20; exp_m[1] = 8'h21; exp_m[2] = 8'h22;
        exp_m[3] = 8'h23; exp_m[4] = 8'h24; exp_m[5] = 8'h26;
        apply_reset();
        mon_q.delete();
        mon_en = 1'b1;
        for (int t = 0; t < 8; t++) begin
            for (int k = 1; k <= 4; k++) begin
                drive(k, {8'h00, 4'(k), 4'(t)});
            end
            step();
            if (t == 5) begin
                checks++; if (g1_drop_cnt !== 8'd0) begin fails++; $display("FAIL full_pop_drop: got %0d want 0", g1_drop_cnt); end
            end
            if (t == 6) begin
                checks++; if (g1_drop_cnt !== 8'd1) begin fails++; $display("FAIL full_drop: got %0d want 1", g1_drop_cnt); end
            end
        end
        clear_inputs();
        checks++; if (drops !== {8'd3, 8'd2, 8'd2, 8'd2}) begin fails++; $display("FAIL overflow_drops: got %h want 03020202", drops); end
        repeat (40) step();
        mon_en = 1'b0;
        checks++; if (mon_q.size() !== 6) begin fails++; $display("FAIL overflow_count: got %0d want 6", mon_q.size()); end
        for (int n = 0; n < 6; n++) begin
            if (n < mon_q.size()) begin
                checks++;
                if (mon_q[n] !== exp_m[n]) begin fails++; $display("FAIL overflow_order_%0d: got %h want %h", n, mon_q[n], exp_m[n]); end
            end
        end
    endtask

    task automatic test_saturation();
        apply_reset();
        for (int t = 0; t < 500; t++) begin
            for (int k = 1; k <= 4; k++) begin
                drive(k, {8'h00, 4'(k), 4'h0});
            end
            step();
        end
        checks++; if (drops !== 32'hFFFF_FFFF) begin fails++; $display("FAIL saturation: got %h want ffffffff", drops); end
    endtask

    // Follows test_saturation directly: FIFOs are full and counters at 255.
    task automatic test_reset_midstream();
        logic quiet;
        clear_inputs();
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++; if (vld !== 4'h0) begin fails++; $display("FAIL midreset_valid: got %b want 0000", vld); end
        checks++; if (drops !== 32'h0) begin fails++; $display("FAIL midreset_drops: got %h want 0", drops); end
        quiet = 1'b1;
        for (int n = 0; n < 6; n++) begin
            step();
            if (vld !== 4'h0) quiet = 1'b0;
        end
        checks++; if (quiet !== 1'b1) begin fails++; $display("FAIL midreset_flushed: got %b want 1", quiet); end
        drive(4, 16'h1077);
        step();
        clear_inputs();
        checks++; if (vld !== 4'h0) begin fails++; $display("FAIL midreset_early: got %b want 0000", vld); end
        step();
        checks++;
        if (vld !== 4'b0010 || g2_out_data !== 16'h1077) begin
            fails++;
            $display("FAIL midreset_latency: got valid %b data %h want 0010 1077", vld, g2_out_data);
        end
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        test_reset();
        test_single_flit();
        test_contention();
        test_parallel();
        test_hairpin();
        test_overflow_full_pop();
        test_saturation();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule : tb_spine_switch
`default_nettype wire
